// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI bus request/response types.
// Contents:
//   obi_req_t  - req, we, be, addr, wdata driven by a requester
//   obi_resp_t - gnt, rvalid, rdata returned to a requester
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cpu_obi_arbiter_if.sv
// cpu_obi_arbiter_if: bundle of every bus signal around the OBI arbiter.
// Signals:
//   up_req/up_resp   - per-requester upstream request and response
//   dn_req/dn_resp   - shared downstream request and response
//   spurious         - sticky rvalid-without-outstanding flag
// Modports: master = environment around the arbiter, slave = arbiter side.
interface cpu_obi_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import obi_pkg::*;

    obi_req_t  [NUM_REQ-1:0] up_req;
    obi_resp_t [NUM_REQ-1:0] up_resp;
    obi_req_t                dn_req;
    obi_resp_t               dn_resp;
    logic                    spurious;

    modport master (output up_req, input up_resp, input dn_req, output dn_resp, input spurious);
    modport slave  (input up_req, output up_resp, output dn_req, input dn_resp, output spurious);

endinterface

// File: rtl/cpu_obi_arb_id_fifo.sv
// cpu_obi_arb_id_fifo: in-order FIFO of requester IDs awaiting rvalid.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_push/i_data - enqueue an ID (accepted when not full, or full with a pop)
//   i_pop         - dequeue the head (ignored when empty)
//   o_head        - oldest ID
//   o_full/o_empty/o_count - occupancy
module cpu_obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CNT_W'(DEPTH);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    // a full FIFO can still take a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= nxt(r_wptr);
            if (w_pop) r_rptr <= nxt(r_rptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/cpu_obi_arbiter.sv
// cpu_obi_arbiter: round-robin arbiter sharing one OBI port among NUM_REQ requesters.
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   req_i / resp_o    - upstream requests and their gnt/rvalid/rdata
//   req_o / resp_i    - shared downstream request and response
//   spurious_rvalid_o - sticky: an rvalid arrived with nothing outstanding
// Request and response paths are combinational (zero added latency).
module cpu_obi_arbiter
    import obi_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  obi_req_t  [NUM_REQ-1:0] req_i,
    output obi_resp_t [NUM_REQ-1:0] resp_o,
    output obi_req_t                req_o,
    input  obi_resp_t               resp_i,
    output logic                    spurious_rvalid_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, WAIT_GNT} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr, r_lock_idx;
    logic               r_spurious;
    logic [IDX_W-1:0]   w_sel, w_head;
    logic               w_sel_vld, w_grant, w_pop, w_can_issue, w_full, w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [NUM_REQ-1:0] w_gnt_vec, w_rv_vec;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        return IDX_W'(j >= NUM_REQ ? j - NUM_REQ : j);
    endfunction

    // a full ID FIFO can still issue when the head retires in this same cycle
    assign w_can_issue = (w_count < CNT_W'(MAX_OUTSTANDING)) || (w_full && resp_i.rvalid);

    // scanning downward lets the lowest offset from rr_ptr overwrite the rest
    always_comb begin
        w_sel     = r_lock_idx;
        w_sel_vld = !rst_i && r_state == WAIT_GNT;
        if (!rst_i && r_state == IDLE && w_can_issue)
            for (int k = NUM_REQ - 1; k >= 0; k--)
                if (req_i[rr_idx(r_rr_ptr, k)].req) begin
                    w_sel     = rr_idx(r_rr_ptr, k);
                    w_sel_vld = 1'b1;
                end
    end

    assign req_o             = w_sel_vld ? req_i[w_sel] : '0;
    assign w_grant           = req_o.req && resp_i.gnt;
    assign w_pop             = !rst_i && resp_i.rvalid && !w_empty;
    assign spurious_rvalid_o = r_spurious;

    always_comb begin
        w_gnt_vec         = '0;
        w_rv_vec          = '0;
        w_gnt_vec[w_sel]  = w_grant;
        w_rv_vec[w_head]  = w_pop;
        for (int i = 0; i < NUM_REQ; i++)
            resp_o[i] = '{gnt: w_gnt_vec[i], rvalid: w_rv_vec[i], rdata: resp_i.rdata};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_grant) r_rr_ptr <= rr_idx(w_sel, 1);
            if (resp_i.rvalid && w_empty) r_spurious <= 1'b1;
            // lock the stalled requester so address and data stay put until gnt
            if (r_state == IDLE && req_o.req && !resp_i.gnt) begin
                r_state    <= WAIT_GNT;
                r_lock_idx <= w_sel;
            end else if (w_grant) begin
                r_state <= IDLE;
            end
        end
    end

    cpu_obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_grant),
        .i_data  (w_sel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(w_gnt_vec));
    a_rv_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(w_rv_vec));
    a_wait_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == WAIT_GNT && !resp_i.gnt) |=> $stable(req_o));

endmodule

// File: tb/tb_cpu_obi_arbiter.sv
// tb_cpu_obi_arbiter: table-driven directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_cpu_obi_arbiter;
    import obi_pkg::*;

    localparam int N = 2;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_obi_arbiter_if #(.NUM_REQ(N)) bus ();

    cpu_obi_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (bus.up_req),
        .resp_o            (bus.up_resp),
        .req_o             (bus.dn_req),
        .resp_i            (bus.dn_resp),
        .spurious_rvalid_o (bus.spurious)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  r;
        logic        g;
        logic        v;
        logic [31:0] rd;
        logic        eq;
        logic [31:0] ea;
        logic [1:0]  eg;
        logic [1:0]  ev;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [N-1:0] gvec();
        logic [N-1:0] x;
        for (int i = 0; i < N; i++) x[i] = bus.up_resp[i].gnt;
        return x;
    endfunction

    function automatic logic [N-1:0] rvec();
        logic [N-1:0] x;
        for (int i = 0; i < N; i++) x[i] = bus.up_resp[i].rvalid;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] rd);
        for (int i = 0; i < N; i++)
            bus.up_req[i] = '{req: r[i], we: 1'b0, be: 4'hF, addr: (i == 0) ? 32'h100 : 32'h200, wdata: 32'h0};
        bus.dn_resp = '{gnt: g, rvalid: v, rdata: rd};
    endtask

    task automatic chk_row(input string tag, input vec_t t);
        chk({tag, ".req"}, 96'(bus.dn_req.req), 96'(t.eq));
        chk({tag, ".addr"}, 96'(bus.dn_req.addr), 96'(t.ea));
        chk({tag, ".gnt"}, 96'(gvec()), 96'(t.eg));
        chk({tag, ".rvalid"}, 96'(rvec()), 96'(t.ev));
        chk({tag, ".spur"}, 96'(bus.spurious), 96'(t.es));
        chk({tag, ".rdata1"}, 96'(bus.up_resp[1].rdata), 96'(t.rd));
    endtask

    obi_req_t   rq [N];
    logic       pend [N];
    int         q[$];
    int         rr, lock, sel;
    logic       spur, grant, g, v;
    logic [31:0] rd;
    obi_req_t   exp_req;
    logic [N-1:0] exp_g, exp_v;

    initial begin
        // directed: both requesters alternate, rvalid one cycle after each gnt
        tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 2'b01, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b1, 32'hA1,       1'b1, 32'h200, 2'b10, 2'b01, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b1, 32'hA2,       1'b1, 32'h100, 2'b01, 2'b10, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b1, 32'hA3,       1'b1, 32'h200, 2'b10, 2'b01, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 32'hA4,       1'b0, 32'h0,   2'b00, 2'b10, 1'b0});
        // gnt withheld three cycles: requester 0 stays locked at 0x100
        tbl.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 2'b01, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200, 2'b10, 2'b00, 1'b0});
        // two outstanding: third request blocked, then issued alongside an rvalid
        tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b1, 32'hB1,       1'b1, 32'h100, 2'b01, 2'b01, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 32'hB2,       1'b0, 32'h0,   2'b00, 2'b10, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 32'hB3,       1'b0, 32'h0,   2'b00, 2'b01, 1'b0});
        // rvalid with nothing outstanding
        tbl.push_back('{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   2'b00, 2'b00, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   2'b00, 2'b00, 1'b1});
        tbl.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 2'b01, 2'b00, 1'b1});
        tbl.push_back('{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200, 2'b10, 2'b00, 1'b1});

        // reset holds outputs low even with active inputs
        drive(2'b11, 1'b1, 1'b1, 32'h5);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", 96'(bus.dn_req.req), 96'(0));
        chk("rst.gnt", 96'(gvec()), 96'(0));
        chk("rst.rvalid", 96'(rvec()), 96'(0));
        chk("rst.spur", 96'(bus.spurious), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].v, tbl[i].rd);
            #1;
            chk_row($sformatf("row%0d", i), tbl[i]);
            @(negedge clk);
        end

        // asynchronous reset with two transactions outstanding
        drive(2'b11, 1'b1, 1'b1, 32'h77);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.req", 96'(bus.dn_req.req), 96'(0));
        chk("arst.gnt", 96'(gvec()), 96'(0));
        chk("arst.rvalid", 96'(rvec()), 96'(0));
        chk("arst.spur", 96'(bus.spurious), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        #1;
        chk("arst.first_gnt", 96'(gvec()), 96'(2'b01));
        chk("arst.first_addr", 96'(bus.dn_req.addr), 96'(32'h100));
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1, 32'h11);
        #1;
        chk("arst.rv_new", 96'(rvec()), 96'(2'b01));
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1, 32'h22);
        #1;
        chk("arst.rv_stale", 96'(rvec()), 96'(0));
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("arst.spur", 96'(bus.spurious), 96'(1));

        // randomized traffic against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        rr = 0;
        lock = -1;
        spur = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    rq[i] = '{req: 1'b1, we: 1'($urandom), be: 4'($urandom), addr: $urandom, wdata: $urandom};
                end else if (!pend[i]) begin
                    rq[i] = '{req: 1'b0, we: 1'($urandom), be: 4'($urandom), addr: $urandom, wdata: $urandom};
                end
                bus.up_req[i] = rq[i];
            end
            g  = $urandom_range(0, 2) != 0;
            v  = q.size() > 0 && $urandom_range(0, 1) == 1;
            rd = $urandom;
            bus.dn_resp = '{gnt: g, rvalid: v, rdata: rd};
            #1;
            sel = -1;
            if (lock >= 0) sel = lock;
            else if (q.size() < M || (q.size() == M && v))
                for (int k = 0; k < N; k++)
                    if (rq[(rr + k) % N].req) begin
                        sel = (rr + k) % N;
                        break;
                    end
            exp_req = (sel >= 0) ? rq[sel] : '0;
            grant   = sel >= 0 && rq[sel].req && g;
            exp_g   = grant ? (N'(1) << sel) : '0;
            exp_v   = (v && q.size() > 0) ? (N'(1) << q[0]) : '0;
            chk("rnd.req_o", 96'(bus.dn_req), 96'(exp_req));
            chk("rnd.gnt", 96'(gvec()), 96'(exp_g));
            chk("rnd.rvalid", 96'(rvec()), 96'(exp_v));
            chk("rnd.rdata0", 96'(bus.up_resp[0].rdata), 96'(rd));
            chk("rnd.spur", 96'(bus.spurious), 96'(spur));
            if (v && q.size() > 0) void'(q.pop_front());
            else if (v) spur = 1'b1;
            if (grant) begin
                q.push_back(sel);
                rr = (sel + 1) % N;
                lock = -1;
                pend[sel] = 1'b0;
            end else if (sel >= 0 && rq[sel].req) begin
                lock = sel;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
